// File: rtl/module_top_enco_gray.sv
// Binary-to-Gray encoder board top. Switches are synchronized and debounced,
// then Gray-encoded onto LEDs and a 2-digit multiplexed 7-segment display.
module module_top_enco_gray #(
   parameter int unsigned DEBOUNCE_W = 20,
   parameter int unsigned REFRESH_W  = 16
) (
   input  logic       clk_pi,
   input  logic       rst_pi,
   input  logic [3:0] codigo_bin_pi,
   output logic [1:0] anodo_po,
   output logic [6:0] catodo_po,
   output logic [3:0] codigo_gray_led_po
);

   localparam int unsigned DATA_W = 4;
   localparam logic [DEBOUNCE_W-1:0] CNT_MAX = '1;
   localparam logic [REFRESH_W-1:0]  RC_MAX  = '1;
   localparam logic [6:0]            SEG_BLANK = 7'h7F;

   logic [DATA_W-1:0]     r_s1;
   logic [DATA_W-1:0]     r_s2;
   logic [DATA_W-1:0]     r_s2_q;
   logic [DATA_W-1:0]     r_stable;
   logic [DEBOUNCE_W-1:0] r_cnt;
   logic [REFRESH_W-1:0]  r_rc;
   logic                  r_sel;

   logic [DATA_W-1:0]     w_gray;
   logic [DATA_W-1:0]     w_units;
   logic                  w_tens;

   // Active-low segment pattern {g,f,e,d,c,b,a} for one decimal digit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Two-flop synchronizer plus a settle-window debounce on the synced value.
   always_ff @(posedge clk_pi) begin
      if (rst_pi) begin
         r_s1     <= '0;
         r_s2     <= '0;
         r_s2_q   <= '0;
         r_stable <= '0;
         r_cnt    <= '0;
      end else begin
         r_s1   <= codigo_bin_pi;
         r_s2   <= r_s1;
         r_s2_q <= r_s2;
         if ((r_s2 != r_s2_q) || (r_s2 == r_stable)) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_stable <= r_s2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + DEBOUNCE_W'(1);
         end
      end
   end

   // Free-running refresh counter; digit select flips on each wrap.
   always_ff @(posedge clk_pi) begin
      if (rst_pi) begin
         r_rc  <= '0;
         r_sel <= 1'b0;
      end else begin
         r_rc <= r_rc + REFRESH_W'(1);
         if (r_rc == RC_MAX) begin
            r_sel <= ~r_sel;
         end
      end
   end

   assign w_gray             = r_stable ^ (r_stable >> 1);
   assign codigo_gray_led_po = w_gray;
   assign w_tens             = (w_gray >= 4'd10);
   assign w_units            = w_tens ? (w_gray - 4'd10) : w_gray;

   // Digit mux; a zero tens digit is blanked.
   always_comb begin
      anodo_po  = 2'b10;
      catodo_po = seg7(w_units);
      if (r_sel) begin
         anodo_po  = 2'b01;
         catodo_po = w_tens ? seg7(4'd1) : SEG_BLANK;
      end
   end

endmodule

// File: tb/tb_module_top_enco_gray.sv
// Directed bench for module_top_enco_gray: expected outputs are queued with the
// edge index at which they must hold, then popped and compared at that edge.
module tb_module_top_enco_gray;

   localparam int DW  = 4;
   localparam int RW  = 3;
   localparam int LAT = (1 << DW) + 3;
   localparam int PER = 1 << RW;

   logic       clk_pi = 1'b0;
   logic       rst_pi;
   logic [3:0] codigo_bin_pi;
   logic [1:0] anodo_po;
   logic [6:0] catodo_po;
   logic [3:0] codigo_gray_led_po;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      string      tag;
      int         at;
      logic [3:0] led;
      logic [1:0] an;
      logic [6:0] cat;
   } exp_t;

   exp_t sb[$];

   module_top_enco_gray #(.DEBOUNCE_W(DW), .REFRESH_W(RW)) dut (
      .clk_pi             (clk_pi),
      .rst_pi             (rst_pi),
      .codigo_bin_pi      (codigo_bin_pi),
      .anodo_po           (anodo_po),
      .catodo_po          (catodo_po),
      .codigo_gray_led_po (codigo_gray_led_po)
   );

   always #5 clk_pi = ~clk_pi;

   // Edge index since the last reset edge; the refresh phase is derived from it.
   always @(posedge clk_pi) begin
      if (rst_pi) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   function automatic logic [3:0] f_gray(input logic [3:0] b);
      return b ^ {1'b0, b[3:1]};
   endfunction

   function automatic logic [6:0] f_seg(input int d);
      logic [6:0] t [10];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return t[d];
   endfunction

   task automatic expect_at(input string tag, input int at, input logic [3:0] g);
      exp_t e;
      int   v;
      v     = int'(g);
      e.tag = tag;
      e.at  = at;
      e.led = g;
      if (((at / PER) % 2) == 1) begin
         e.an  = 2'b01;
         e.cat = (v >= 10) ? f_seg(1) : 7'h7F;
      end else begin
         e.an  = 2'b10;
         e.cat = f_seg(v % 10);
      end
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      int   n;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n = 0;
         while (cyc < e.at && n < 1000) begin
            @(negedge clk_pi);
            n++;
         end
         vectors++;
         assert (cyc === e.at) else begin
            miscompares++;
            $error("FAIL %s timing: at edge %0d, required edge %0d", e.tag, cyc, e.at);
         end
         vectors++;
         assert (codigo_gray_led_po === e.led) else begin
            miscompares++;
            $error("FAIL %s led @%0d: got %b want %b", e.tag, cyc, codigo_gray_led_po, e.led);
         end
         vectors++;
         assert (anodo_po === e.an) else begin
            miscompares++;
            $error("FAIL %s anodo @%0d: got %b want %b", e.tag, cyc, anodo_po, e.an);
         end
         vectors++;
         assert (catodo_po === e.cat) else begin
            miscompares++;
            $error("FAIL %s catodo @%0d: got %h want %h", e.tag, cyc, catodo_po, e.cat);
         end
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk_pi);
   endtask

   // Holds reset for n edges with the given switch value; releases at edge 0.
   task automatic do_reset(input logic [3:0] v, input int n);
      rst_pi        = 1'b1;
      codigo_bin_pi = v;
      step(n);
      rst_pi        = 1'b0;
   endtask

   initial begin
      logic [3:0] prev;
      int         c0;
      int         c1;
      int         t;

      rst_pi        = 1'b0;
      codigo_bin_pi = 4'b0000;
      step(2);

      // Reset with switches already at 1010, then refresh phase checks.
      do_reset(4'b1010, 3);
      expect_at("rst_val",    0,       4'b0000);
      expect_at("rst_tens",   8,       4'b0000);
      expect_at("rst_units",  16,      4'b0000);
      expect_at("rst_hold",   LAT - 1, 4'b0000);
      expect_at("rst_accept", LAT,     4'b1111);
      expect_at("rst_tens1",  24,      4'b1111);
      drain();

      // Clean step 0000 -> 0101, checked on every edge of the window.
      do_reset(4'b0000, 3);
      codigo_bin_pi = 4'b0101;
      for (int k = 1; k < LAT; k++) expect_at("step_hold", k, 4'b0000);
      expect_at("step_new",   LAT, 4'b0111);
      expect_at("step_blank", 24,  4'b0111);
      drain();

      // Full sweep of all 16 values, both digits checked for each.
      prev = 4'b0111;
      for (int b = 0; b < 16; b++) begin
         c0            = cyc;
         codigo_bin_pi = 4'(b);
         expect_at("sweep_old", c0 + LAT - 1, prev);
         expect_at("sweep_new", c0 + LAT,     f_gray(4'(b)));
         t = c0 + LAT + 1;
         while (((t / PER) % 2) == (((c0 + LAT) / PER) % 2)) t++;
         expect_at("sweep_alt", t, f_gray(4'(b)));
         drain();
         while (cyc < c0 + 40) @(negedge clk_pi);
         prev = f_gray(4'(b));
      end

      // Bounce between 0000 and 0011 every 5 cycles, then settle at 0011.
      do_reset(4'b0000, 3);
      for (int i = 0; i < 8; i++) begin
         expect_at("bounce_hold", cyc, 4'b0000);
         drain();
         codigo_bin_pi = ((i % 2) == 0) ? 4'b0011 : 4'b0000;
         step(5);
      end
      c0            = cyc;
      codigo_bin_pi = 4'b0011;
      expect_at("bounce_wait",   c0 + LAT - 1, 4'b0000);
      expect_at("bounce_settle", c0 + LAT,     4'b0010);
      drain();

      // Two-cycle glitch of 0001 on a stable 0000 is never accepted.
      do_reset(4'b0000, 3);
      c0            = cyc;
      codigo_bin_pi = 4'b0001;
      step(2);
      codigo_bin_pi = 4'b0000;
      for (int k = 3; k <= 40; k++) expect_at("glitch", c0 + k, 4'b0000);
      drain();

      // Mid-window reset discards the count; a new value after release is re-debounced.
      c0            = cyc;
      codigo_bin_pi = 4'b1111;
      expect_at("pre_rst", c0 + LAT, 4'b1000);
      drain();
      while (cyc < c0 + 40) @(negedge clk_pi);
      c1            = cyc;
      codigo_bin_pi = 4'b0000;
      expect_at("mid_window", c1 + 10, 4'b1000);
      drain();
      rst_pi        = 1'b1;
      codigo_bin_pi = 4'b0110;
      step(1);
      expect_at("mid_rst", 0, 4'b0000);
      drain();
      rst_pi = 1'b0;
      expect_at("post_rst_hold", LAT - 1, 4'b0000);
      expect_at("post_rst_new",  LAT,     4'b0101);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
